// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: immediate-extension mode encoding,
// reused by the extender and the control FSM.
package mips_pkg;

    typedef logic [1:0] imm_mode_t;

    localparam imm_mode_t IMM_MODE_SIGN   = 2'b00;
    localparam imm_mode_t IMM_MODE_ZERO   = 2'b01;
    localparam imm_mode_t IMM_MODE_UPPER  = 2'b10;
    localparam imm_mode_t IMM_MODE_BRANCH = 2'b11;

endpackage

// File: rtl/imm_extend_core.sv
// Pure combinational immediate extender: sign, zero, upper (LUI) and branch.
// Branch (sign-extend then <<2) exists only when IMM_EXTEND_BRANCH_EN is defined.
module imm_extend_core
    import mips_pkg::*;
#(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
) (
    input  logic [IMM_W-1:0] i_imm,
    input  imm_mode_t        i_mode,
    output logic [OUT_W-1:0] o_result
);

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_upper;

    assign w_sext  = {{(OUT_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
    assign w_zext  = {{(OUT_W-IMM_W){1'b0}}, i_imm};
    // Width is exactly OUT_W, so only the shifted-in low bits are zero.
    assign w_upper = {i_imm, {(OUT_W-IMM_W){1'b0}}};

`ifdef IMM_EXTEND_BRANCH_EN
    logic [OUT_W-1:0] w_branch;
    assign w_branch = {w_sext[OUT_W-3:0], 2'b00};
`endif

    always_comb begin
        o_result = w_sext;
        case (i_mode)
            IMM_MODE_ZERO:   o_result = w_zext;
            IMM_MODE_UPPER:  o_result = w_upper;
`ifdef IMM_EXTEND_BRANCH_EN
            IMM_MODE_BRANCH: o_result = w_branch;
`endif
            default:         o_result = w_sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate extender with a 2-entry output FIFO and valid/ready on both sides.
// Optional macro IMM_EXTEND_BRANCH_EN enables mode 11 as a branch offset (sext << 2).
module imm_extend_unit
    import mips_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int IMM_W   = 16,
    parameter int OUT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [1:0]         mode_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   imm_out,
    output logic [1:0]         out_mode
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid and its payload stay stable until that edge, and ready never
    // depends combinationally on the opposite side's valid or ready.

    if (OUT_W < IMM_W + 2) begin : g_width_check
        $error("imm_extend_unit: OUT_W must be at least IMM_W+2");
    end

    logic [OUT_W-1:0] r_entry_imm  [2];
    imm_mode_t        r_entry_mode [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;
    logic             w_unused_instr;

    // Only the low IMM_W bits feed the extender; the opcode/register fields are ignored.
    assign w_unused_instr = ^instr_in;

    imm_extend_core #(
        .IMM_W (IMM_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_imm    (instr_in[IMM_W-1:0]),
        .i_mode   (mode_in),
        .o_result (w_ext)
    );

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign imm_out   = r_entry_imm[r_rd_ptr];
    assign out_mode  = r_entry_mode[r_rd_ptr];

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_entry_imm[i]  <= '0;
                r_entry_mode[i] <= IMM_MODE_SIGN;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            // A push never targets the head slot while it is valid, so imm_out holds under stall.
            if (w_push) begin
                r_entry_imm[r_wr_ptr]  <= w_ext;
                r_entry_mode[r_wr_ptr] <= mode_in;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == 2'd2)));

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_pop && (r_count == 2'd0)));

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed testbench for imm_extend_unit: reset, each extension mode,
// backpressure, full-rate streaming, asynchronous reset mid-transfer, branch mode.
module tb_imm_extend_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic [1:0]  mode_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;
    logic [1:0]  out_mode;

    int n_checks;
    int n_fail;

    imm_extend_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr_in  (instr_in),
        .mode_in   (mode_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_out   (imm_out),
        .out_mode  (out_mode)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers: inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [1:0] mode);
        in_valid = v;
        instr_in = instr;
        mode_in  = mode;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 2'b00);
        out_ready = 1'b1;
        #12;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (imm_out !== 32'h0) begin n_fail++; $display("FAIL reset_imm_out: got %h expected 00000000", imm_out); end
        n_checks++;
        if (out_mode !== 2'b00) begin n_fail++; $display("FAIL reset_out_mode: got %b expected 00", out_mode); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sign();
        out_ready = 1'b1;
        drive(1'b1, 32'h2008FFFC, 2'b00);
        step();
        drive(1'b0, 32'h0, 2'b00);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sign_valid: got %b expected 1", out_valid); end
        n_checks++;
        if (imm_out !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL sign_imm: got %h expected FFFFFFFC", imm_out); end
        n_checks++;
        if (out_mode !== 2'b00) begin n_fail++; $display("FAIL sign_mode: got %b expected 00", out_mode); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sign_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_zero_upper();
        out_ready = 1'b1;
        drive(1'b1, 32'h3508ABCD, 2'b01);
        step();
        n_checks++;
        if (imm_out !== 32'h0000ABCD) begin n_fail++; $display("FAIL zero_imm: got %h expected 0000ABCD", imm_out); end
        n_checks++;
        if (out_mode !== 2'b01) begin n_fail++; $display("FAIL zero_mode: got %b expected 01", out_mode); end
        drive(1'b1, 32'h3C081234, 2'b10);
        step();
        drive(1'b0, 32'h0, 2'b00);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL upper_valid: got %b expected 1", out_valid); end
        n_checks++;
        if (imm_out !== 32'h12340000) begin n_fail++; $display("FAIL upper_imm: got %h expected 12340000", imm_out); end
        n_checks++;
        if (out_mode !== 2'b10) begin n_fail++; $display("FAIL upper_mode: got %b expected 10", out_mode); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL upper_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h00000005, 2'b00);
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %b expected 1", in_ready); end
        n_checks++;
        if (imm_out !== 32'h00000005) begin n_fail++; $display("FAIL bp_first: got %h expected 00000005", imm_out); end
        drive(1'b1, 32'h0000FFF0, 2'b01);
        step();
        // Third word stays offered while the buffer is full.
        drive(1'b1, 32'h00007777, 2'b00);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready[%0d]: got %b expected 0", i, in_ready); end
            n_checks++;
            if (out_valid !== 1'b1 || imm_out !== 32'h00000005) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b imm=%h expected valid=1 imm=00000005", i, out_valid, imm_out);
            end
            step();
        end
        drive(1'b0, 32'h0, 2'b00);
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || imm_out !== 32'h0000FFF0 || out_mode !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_second: got valid=%b imm=%h mode=%b expected valid=1 imm=0000FFF0 mode=01", out_valid, imm_out, out_mode);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b expected 1", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h20080000 | (32'h8000 + i), 2'b00);
            exp_q.push_back(32'hFFFF8000 + i);
            step();
            exp = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || imm_out !== exp || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream[%0d]: got valid=%b ready=%b imm=%h expected valid=1 ready=1 imm=%h", i, out_valid, in_ready, imm_out, exp);
            end
        end
        drive(1'b0, 32'h0, 2'b00);
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'h00001111, 2'b10);
        step();
        drive(1'b1, 32'h00002222, 2'b01);
        step();
        drive(1'b0, 32'h0, 2'b00);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_full_before: got %b expected 0", in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_flags: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
        n_checks++;
        if (imm_out !== 32'h0 || out_mode !== 2'b00) begin
            n_fail++;
            $display("FAIL rm_data: got imm=%h mode=%b expected imm=00000000 mode=00", imm_out, out_mode);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stale[%0d]: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_neg;
        logic [31:0] exp_pos;
`ifdef IMM_EXTEND_BRANCH_EN
        exp_neg = 32'hFFFFFFFC;
        exp_pos = 32'h00000004;
`else
        exp_neg = 32'hFFFFFFFF;
        exp_pos = 32'h00000001;
`endif
        out_ready = 1'b1;
        drive(1'b1, 32'h1000FFFF, 2'b11);
        step();
        n_checks++;
        if (imm_out !== exp_neg || out_mode !== 2'b11) begin
            n_fail++;
            $display("FAIL branch_neg: got imm=%h mode=%b expected imm=%h mode=11", imm_out, out_mode, exp_neg);
        end
        drive(1'b1, 32'h10000001, 2'b11);
        step();
        drive(1'b0, 32'h0, 2'b00);
        n_checks++;
        if (imm_out !== exp_pos) begin n_fail++; $display("FAIL branch_pos: got %h expected %h", imm_out, exp_pos); end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sign();
        test_zero_upper();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_branch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
